// File: rtl/legendre_mac_pkg.sv
// Shared definitions for the Legendre segment-finder multiply-accumulate pipe:
// mode encoding, saturation/sign-extension helpers and parameter legality.
package legendre_mac_pkg;

    localparam int MAX_W = 128;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_ACC = 1'b1
    } mac_mode_e;

    // Upper bit to prepend to operand A so a single extension bit yields a signed value.
    function automatic logic ext_bit(input logic msb, input bit is_signed);
        return is_signed & msb;
    endfunction

    function automatic logic signed [MAX_W-1:0] sat(input logic signed [MAX_W-1:0] value,
                                                   input int width);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = $signed({MAX_W{1'b1}} >> (MAX_W - width + 1));
        lo = ~hi;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

    function automatic bit params_ok(input int a_w, input int b_w, input int acc_w,
                                     input int out_w, input int num_stage);
        return (a_w >= 1) && (b_w >= 2) && (num_stage >= 2) && (num_stage <= 6) &&
               (acc_w >= a_w + b_w + 1) && (out_w >= 2) && (out_w <= acc_w) &&
               (acc_w < MAX_W);
    endfunction

endpackage

// File: rtl/legendre_mac_pipe_if.sv
// Beat-level bus between the coefficient stages and the MAC pipe.
interface legendre_mac_pipe_if #(
    parameter int A_WIDTH   = 15,
    parameter int B_WIDTH   = 18,
    parameter int OUT_WIDTH = 33
);
    logic                        in_valid;
    logic [A_WIDTH-1:0]          in_a;
    logic signed [B_WIDTH-1:0]   in_b;
    logic                        in_mode;
    logic                        in_last;
    logic                        out_valid;
    logic signed [OUT_WIDTH-1:0] out_p;
    logic                        out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_mode, in_last,
        input  out_valid, out_p, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mode, in_last,
        output out_valid, out_p, out_ovf
    );
endinterface

// File: rtl/legendre_mac_mult.sv
// DSP-style registered multiplier: input register stage, full-width product and
// NUM_STAGE-2 product delay registers, with control bits travelling alongside.
module legendre_mac_mult
    import legendre_mac_pkg::*;
#(
    parameter int A_WIDTH   = 15,
    parameter int A_SIGNED  = 0,
    parameter int B_WIDTH   = 18,
    parameter int NUM_STAGE = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_ce,
    input  logic                          i_valid,
    input  logic [A_WIDTH-1:0]            i_a,
    input  logic signed [B_WIDTH-1:0]     i_b,
    input  mac_mode_e                     i_mode,
    input  logic                          i_last,
    output logic                          o_valid,
    output logic signed [A_WIDTH+B_WIDTH:0] o_prod,
    output mac_mode_e                     o_mode,
    output logic                          o_last
);
    localparam int P_W = A_WIDTH + B_WIDTH + 1;
    localparam int DLY = NUM_STAGE - 2;

    logic [A_WIDTH-1:0]        r_a;
    logic signed [B_WIDTH-1:0] r_b;
    logic                      r_valid;
    mac_mode_e                 r_mode;
    logic                      r_last;

    logic [A_WIDTH:0]          w_aExt;
    logic signed [P_W-1:0]     w_aP;
    logic signed [P_W-1:0]     w_bP;
    logic signed [P_W-1:0]     w_prod;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
            r_mode  <= MODE_MUL;
            r_last  <= 1'b0;
        end else if (i_ce) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_valid <= i_valid;
            r_mode  <= i_mode;
            r_last  <= i_last;
        end
    end

    // Both operands are widened to the full product width so the multiply never wraps.
    assign w_aExt = {ext_bit(r_a[A_WIDTH-1], A_SIGNED != 0), r_a};
    assign w_aP   = $signed({{B_WIDTH{w_aExt[A_WIDTH]}}, w_aExt});
    assign w_bP   = $signed({{(A_WIDTH+1){r_b[B_WIDTH-1]}}, r_b});
    assign w_prod = w_aP * w_bP;

    if (DLY == 0) begin : g_noDelay
        assign o_valid = r_valid;
        assign o_prod  = w_prod;
        assign o_mode  = r_mode;
        assign o_last  = r_last;
    end else begin : g_delay
        logic signed [P_W-1:0] r_prodPipe  [DLY];
        logic                  r_validPipe [DLY];
        mac_mode_e             r_modePipe  [DLY];
        logic                  r_lastPipe  [DLY];

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                for (int i = 0; i < DLY; i++) begin
                    r_prodPipe[i]  <= '0;
                    r_validPipe[i] <= 1'b0;
                    r_modePipe[i]  <= MODE_MUL;
                    r_lastPipe[i]  <= 1'b0;
                end
            end else if (i_ce) begin
                r_prodPipe[0]  <= w_prod;
                r_validPipe[0] <= r_valid;
                r_modePipe[0]  <= r_mode;
                r_lastPipe[0]  <= r_last;
                for (int i = 1; i < DLY; i++) begin
                    r_prodPipe[i]  <= r_prodPipe[i-1];
                    r_validPipe[i] <= r_validPipe[i-1];
                    r_modePipe[i]  <= r_modePipe[i-1];
                    r_lastPipe[i]  <= r_lastPipe[i-1];
                end
            end
        end

        assign o_valid = r_validPipe[DLY-1];
        assign o_prod  = r_prodPipe[DLY-1];
        assign o_mode  = r_modePipe[DLY-1];
        assign o_last  = r_lastPipe[DLY-1];
    end

endmodule

// File: rtl/legendre_mac_pipe.sv
// Pipelined multiply / burst-accumulate unit with saturating output; the final
// stage holds the accumulator, sticky overflow and the result registers.
module legendre_mac_pipe
    import legendre_mac_pkg::*;
#(
    parameter int A_WIDTH   = 15,
    parameter int A_SIGNED  = 0,
    parameter int B_WIDTH   = 18,
    parameter int ACC_WIDTH = 40,
    parameter int OUT_WIDTH = 33,
    parameter int NUM_STAGE = 3
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             ap_ce,
    legendre_mac_pipe_if.slave bus
);
    localparam int P_W       = A_WIDTH + B_WIDTH + 1;
    localparam bit PARAMS_OK = params_ok(A_WIDTH, B_WIDTH, ACC_WIDTH, OUT_WIDTH, NUM_STAGE);

    if (!PARAMS_OK) begin : g_paramCheck
        $error("legendre_mac_pipe: illegal parameter combination");
    end

    logic                        w_multValid;
    logic signed [P_W-1:0]       w_prod;
    mac_mode_e                   w_mode;
    logic                        w_last;

    logic signed [MAX_W-1:0]     w_prodWide;
    logic signed [MAX_W-1:0]     w_accWide;
    logic signed [MAX_W-1:0]     w_sumWide;
    logic signed [MAX_W-1:0]     w_accSatWide;
    logic signed [MAX_W-1:0]     w_selWide;
    logic signed [MAX_W-1:0]     w_outSatWide;
    logic                        w_accOvf;
    logic                        w_outOvf;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_sticky;
    logic                        r_burstActive;
    logic                        r_outValid;
    logic signed [OUT_WIDTH-1:0] r_outP;
    logic                        r_outOvf;

    legendre_mac_mult #(
        .A_WIDTH   (A_WIDTH),
        .A_SIGNED  (A_SIGNED),
        .B_WIDTH   (B_WIDTH),
        .NUM_STAGE (NUM_STAGE)
    ) u_mult (
        .i_clk   (ap_clk),
        .i_rst   (ap_rst),
        .i_ce    (ap_ce),
        .i_valid (bus.in_valid),
        .i_a     (bus.in_a),
        .i_b     (bus.in_b),
        .i_mode  (mac_mode_e'(bus.in_mode)),
        .i_last  (bus.in_last),
        .o_valid (w_multValid),
        .o_prod  (w_prod),
        .o_mode  (w_mode),
        .o_last  (w_last)
    );

    // Accumulator only contributes inside a burst, so the first beat always starts from zero.
    assign w_prodWide   = $signed({{(MAX_W-P_W){w_prod[P_W-1]}}, w_prod});
    assign w_accWide    = r_burstActive ? $signed({{(MAX_W-ACC_WIDTH){r_acc[ACC_WIDTH-1]}}, r_acc})
                                        : '0;
    assign w_sumWide    = w_accWide + w_prodWide;
    assign w_accSatWide = sat(w_sumWide, ACC_WIDTH);
    assign w_accOvf     = (w_accSatWide != w_sumWide);
    assign w_selWide    = (w_mode == MODE_ACC) ? w_accSatWide : w_prodWide;
    assign w_outSatWide = sat(w_selWide, OUT_WIDTH);
    assign w_outOvf     = (w_outSatWide != w_selWide);

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_acc         <= '0;
            r_sticky      <= 1'b0;
            r_burstActive <= 1'b0;
            r_outValid    <= 1'b0;
            r_outP        <= '0;
            r_outOvf      <= 1'b0;
        end else if (ap_ce) begin
            r_outValid <= 1'b0;
            if (w_multValid) begin
                if (w_mode == MODE_MUL) begin
                    r_outP     <= w_outSatWide[OUT_WIDTH-1:0];
                    r_outOvf   <= w_outOvf;
                    r_outValid <= 1'b1;
                end else if (w_last) begin
                    r_outP        <= w_outSatWide[OUT_WIDTH-1:0];
                    r_outOvf      <= r_sticky | w_accOvf | w_outOvf;
                    r_outValid    <= 1'b1;
                    r_acc         <= '0;
                    r_sticky      <= 1'b0;
                    r_burstActive <= 1'b0;
                end else begin
                    r_acc         <= w_accSatWide[ACC_WIDTH-1:0];
                    r_sticky      <= r_sticky | w_accOvf;
                    r_burstActive <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = r_outValid;
    assign bus.out_p     = r_outP;
    assign bus.out_ovf   = r_outOvf;

endmodule
